xls_fifo_pop_unpacker: RTL and testbench

- Pop-side consumer for the single-entry XLS channel FIFO.
- Drains wide words from a FIFO pop interface (valid/ready) and re-emits each word as a sequence of narrower beats on a valid/ready output stream.
- Supports partial final words and frame-end marking.
- Used in zstd where wide FIFO words feed byte/sub-word consumers.

---
 rtl/xls_fifo_pop_unpacker_pkg.sv | 22 ++
 rtl/xls_fifo_pop_unpacker_slice_mux.sv | 33 +++
 rtl/xls_fifo_pop_unpacker.sv | 95 +++++++++
 tb/tb_xls_fifo_pop_unpacker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/xls_fifo_pop_unpacker_pkg.sv
// Shared definitions for the zstd FIFO pop-side packers/unpackers:
// state encoding, default geometry and beat-count sizing helper.
package xls_fifo_pop_unpacker_pkg;

  localparam int DefInWidth  = 32;
  localparam int DefOutWidth = 8;
  localparam int DefRatio    = DefInWidth / DefOutWidth;
  localparam int DefCntWidth = $clog2(DefRatio) + 1;

  typedef logic [DefCntWidth-1:0] beat_cnt_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Wide enough to hold the value Ratio itself, not just Ratio-1.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

endpackage

// File: rtl/xls_fifo_pop_unpacker_slice_mux.sv
// Combinational Ratio-way slice select of a wide word; beat 0 is either the
// least- or most-significant slice depending on LsbFirst.
module xls_slice_mux #(
  parameter int InWidth  = 32,
  parameter int OutWidth = 8,
  parameter bit LsbFirst = 1'b1,
  parameter int CntWidth = 3
) (
  input  logic [InWidth-1:0]  data_i,
  input  logic [CntWidth-1:0] idx_i,
  output logic [OutWidth-1:0] slice_o
);

  localparam int Ratio = InWidth / OutWidth;

  logic [OutWidth-1:0] slices [Ratio];

  for (genvar gi = 0; gi < Ratio; gi++) begin : g_slice
    if (LsbFirst) begin : g_lsb
      assign slices[gi] = data_i[gi*OutWidth +: OutWidth];
    end else begin : g_msb
      assign slices[gi] = data_i[(Ratio-1-gi)*OutWidth +: OutWidth];
    end
  end

  always_comb begin
    slice_o = '0;
    for (int i = 0; i < Ratio; i++) begin
      if (idx_i == CntWidth'(i)) slice_o = slices[i];
    end
  end

endmodule

// File: rtl/xls_fifo_pop_unpacker.sv
// Pops wide words from a single-entry FIFO and re-emits each one as up to
// Ratio narrow beats, with zero-bubble hand-off between consecutive words.
module xls_fifo_pop_unpacker
  import xls_fifo_pop_unpacker_pkg::*;
#(
  parameter int InWidth  = 32,
  parameter int OutWidth = 8,
  parameter bit LsbFirst = 1'b1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  output logic                                          in_ready,
  input  logic [InWidth-1:0]                            in_data,
  input  logic                                          in_valid,
  input  logic [cnt_width(InWidth/OutWidth)-1:0]        in_nbeats,
  input  logic                                          in_last,
  output logic [OutWidth-1:0]                           out_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          out_last
);

  localparam int Ratio    = InWidth / OutWidth;
  localparam int CntWidth = cnt_width(Ratio);

  state_e               state_q, state_d;
  logic [InWidth-1:0]   data_q, data_d;
  logic [CntWidth-1:0]  nbeats_q, nbeats_d;
  logic [CntWidth-1:0]  idx_q, idx_d;
  logic                 last_q, last_d;

  logic [CntWidth-1:0]  eff_nbeats;
  logic                 final_beat;
  logic                 in_accept;
  logic [OutWidth-1:0]  slice;

  // Out-of-range beat counts mean "whole word".
  assign eff_nbeats = (in_nbeats == '0 || in_nbeats > CntWidth'(Ratio))
                      ? CntWidth'(Ratio) : in_nbeats;

  assign final_beat = (state_q == ST_EMIT) && (idx_q == nbeats_q - CntWidth'(1));
  assign in_ready   = (state_q == ST_IDLE) || (final_beat && out_ready);
  assign in_accept  = in_valid && in_ready;

  assign out_valid  = (state_q == ST_EMIT);
  assign out_last   = final_beat && last_q;
  assign out_data   = out_valid ? slice : '0;

  xls_slice_mux #(
    .InWidth (InWidth),
    .OutWidth(OutWidth),
    .LsbFirst(LsbFirst),
    .CntWidth(CntWidth)
  ) u_slice_mux (
    .data_i (data_q),
    .idx_i  (idx_q),
    .slice_o(slice)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    nbeats_d = nbeats_q;
    idx_d    = idx_q;
    last_d   = last_q;
    // In EMIT an accept can only happen on the taken final beat.
    if (in_accept) begin
      state_d  = ST_EMIT;
      data_d   = in_data;
      nbeats_d = eff_nbeats;
      last_d   = in_last;
      idx_d    = '0;
    end else if (state_q == ST_EMIT && out_ready) begin
      if (final_beat) state_d = ST_IDLE;
      else            idx_d   = idx_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      nbeats_q <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      nbeats_q <= nbeats_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_xls_fifo_pop_unpacker.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are
// checked every cycle against a queue-of-beats reference model.
module tb_xls_fifo_pop_unpacker;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic [2:0]  in_nbeats;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_l, out_valid_l, out_last_l;
  logic [7:0]  out_data_l;
  logic        in_ready_m, out_valid_m, out_last_m;
  logic [7:0]  out_data_m;

  int tests_run = 0;
  int tests_failed = 0;

  xls_fifo_pop_unpacker #(.InWidth(32), .OutWidth(8), .LsbFirst(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_ready(in_ready_l), .in_data(in_data),
    .in_valid(in_valid), .in_nbeats(in_nbeats), .in_last(in_last),
    .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_last(out_last_l)
  );

  xls_fifo_pop_unpacker #(.InWidth(32), .OutWidth(8), .LsbFirst(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_ready(in_ready_m), .in_data(in_data),
    .in_valid(in_valid), .in_nbeats(in_nbeats), .in_last(in_last),
    .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_last(out_last_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the beats still owed downstream, in emission order.
  typedef struct packed {
    logic [7:0] lsb;
    logic [7:0] msb;
    logic       last;
  } beat_t;
  beat_t model_q[$];

  logic [7:0] rec_l[$];
  logic [7:0] rec_m[$];
  logic       rec_last_l[$];
  logic       rec_last_m[$];
  logic       acc_in;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  nb;
    logic        last;
    int          n;
    logic [31:0] exp_l;  // beat k in byte k
    logic [31:0] exp_m;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [31:0] d, input logic [2:0] nb, input logic l);
    int n;
    beat_t b;
    n = (nb == 0 || nb > 4) ? 4 : int'(nb);
    for (int i = 0; i < n; i++) begin
      b.lsb  = d[8*i +: 8];
      b.msb  = d[8*(3-i) +: 8];
      b.last = l && (i == n - 1);
      model_q.push_back(b);
    end
  endtask

  task automatic clear_rec();
    rec_l.delete(); rec_m.delete(); rec_last_l.delete(); rec_last_m.delete();
  endtask

  // One clock cycle: check at the falling edge, advance the model, then
  // return 1 time unit after the rising edge so the caller can drive inputs.
  task automatic tick();
    logic exp_ir;
    @(negedge clk);
    exp_ir = (model_q.size() == 0) || (model_q.size() == 1 && out_ready);
    chk("in_ready_lsb", {31'd0, in_ready_l}, {31'd0, exp_ir});
    chk("in_ready_msb", {31'd0, in_ready_m}, {31'd0, exp_ir});
    chk("out_valid_lsb", {31'd0, out_valid_l}, {31'd0, model_q.size() != 0});
    chk("out_valid_msb", {31'd0, out_valid_m}, {31'd0, model_q.size() != 0});
    if (model_q.size() != 0) begin
      chk("out_data_lsb", {24'd0, out_data_l}, {24'd0, model_q[0].lsb});
      chk("out_data_msb", {24'd0, out_data_m}, {24'd0, model_q[0].msb});
      chk("out_last_lsb", {31'd0, out_last_l}, {31'd0, model_q[0].last});
      chk("out_last_msb", {31'd0, out_last_m}, {31'd0, model_q[0].last});
    end
    if (out_valid_l && out_ready) begin
      rec_l.push_back(out_data_l);
      rec_last_l.push_back(out_last_l);
    end
    if (out_valid_m && out_ready) begin
      rec_m.push_back(out_data_m);
      rec_last_m.push_back(out_last_m);
    end
    acc_in = exp_ir && in_valid;
    if (model_q.size() != 0 && out_ready) begin
      $display("[TB] beat lsb=%h msb=%h last=%0d", model_q[0].lsb, model_q[0].msb, model_q[0].last);
      void'(model_q.pop_front());
    end
    if (acc_in) model_push(in_data, in_nbeats, in_last);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic l);
    bit done = 0;
    in_valid = 1'b1; in_data = d; in_nbeats = nb; in_last = l;
    for (int t = 0; t < 40 && !done; t++) begin
      tick();
      if (acc_in) done = 1;
    end
    if (!done) begin
      tests_run++; tests_failed++;
      $display("FAIL send_word_timeout: got no accept expected accept of %h", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && model_q.size() != 0; t++) tick();
    tick();
    chk("drain_empty", model_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{32'hDDCCBBAA, 3'd4, 1'b1, 4, 32'hDDCCBBAA, 32'hAABBCCDD};
    vecs[1] = '{32'h44332211, 3'd2, 1'b0, 2, 32'h00002211, 32'h00003344};
    vecs[2] = '{32'h44332211, 3'd0, 1'b1, 4, 32'h44332211, 32'h11223344};
    vecs[3] = '{32'h44332211, 3'd7, 1'b0, 4, 32'h44332211, 32'h11223344};
    vecs[4] = '{32'h5A6B7C8D, 3'd1, 1'b1, 1, 32'h0000008D, 32'h0000005A};
    vecs[5] = '{32'h03020100, 3'd3, 1'b1, 3, 32'h00020100, 32'h00010203};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_nbeats = '0; in_last = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid_l}, 0);
    chk("rst_out_last", {31'd0, out_last_l}, 0);
    chk("rst_out_data", {24'd0, out_data_l}, 0);
    chk("rst_out_valid_msb", {31'd0, out_valid_m}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Table-driven single words
    for (int v = 0; v < 6; v++) begin
      clear_rec();
      out_ready = 1'b1;
      send_word(vecs[v].data, vecs[v].nb, vecs[v].last);
      drain();
      chk($sformatf("vec%0d_count_lsb", v), rec_l.size(), vecs[v].n);
      chk($sformatf("vec%0d_count_msb", v), rec_m.size(), vecs[v].n);
      for (int k = 0; k < vecs[v].n && k < rec_l.size() && k < rec_m.size(); k++) begin
        chk($sformatf("vec%0d_beat%0d_lsb", v, k), {24'd0, rec_l[k]}, {24'd0, vecs[v].exp_l[8*k +: 8]});
        chk($sformatf("vec%0d_beat%0d_msb", v, k), {24'd0, rec_m[k]}, {24'd0, vecs[v].exp_m[8*k +: 8]});
        chk($sformatf("vec%0d_last%0d", v, k), {31'd0, rec_last_l[k]},
            {31'd0, vecs[v].last && (k == vecs[v].n - 1)});
      end
    end

    // Back-to-back words: eight consecutive beats 00..07
    clear_rec();
    out_ready = 1'b1;
    send_word(32'h03020100, 3'd4, 1'b0);
    send_word(32'h07060504, 3'd4, 1'b1);
    drain();
    chk("b2b_count", rec_l.size(), 8);
    for (int k = 0; k < 8 && k < rec_l.size(); k++)
      chk($sformatf("b2b_beat%0d", k), {24'd0, rec_l[k]}, k);

    // Backpressure while BB is pending
    clear_rec();
    out_ready = 1'b1;
    send_word(32'hDDCCBBAA, 3'd4, 1'b1);
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    chk("bp_held_data", {24'd0, out_data_l}, 32'hBB);
    drain();
    chk("bp_count", rec_l.size(), 4);

    // Async reset mid-word
    clear_rec();
    out_ready = 1'b1;
    send_word(32'hDDCCBBAA, 3'd4, 1'b1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid_l}, 0);
    chk("arst_out_valid_msb", {31'd0, out_valid_m}, 0);
    chk("arst_out_last", {31'd0, out_last_l}, 0);
    model_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    clear_rec();
    send_word(32'h44332211, 3'd4, 1'b0);
    drain();
    chk("arst_next_count", rec_l.size(), 4);
    if (rec_l.size() > 0) chk("arst_next_beat0", {24'd0, rec_l[0]}, 32'h11);

    // Random soak
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_nbeats = 3'($urandom_range(1, 4));
      in_last   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
